// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: packs the hps_io ROM download byte stream into 16-bit SDRAM writes through a small FIFO.
// Optional build macro IOCTL_LOADER_CHECKSUM_EN enables the running 16-bit byte checksum on o_CHECKSUM.
module ioctl_rom_loader #(
    parameter int ROM_INDEX  = 0,
    parameter int SDRAM_AW   = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_EMU_MCLK,
    input  logic                i_EMU_RST_n,
    input  logic                ioctl_download,
    input  logic [15:0]         ioctl_index,
    input  logic                ioctl_wr,
    input  logic [26:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    output logic                ioctl_wait,
    output logic                o_SDRAM_REQ,
    output logic [SDRAM_AW-1:0] o_SDRAM_ADDR,
    output logic [15:0]         o_SDRAM_DATA,
    output logic [1:0]          o_SDRAM_BE,
    input  logic                i_SDRAM_ACK,
    output logic                o_BUSY,
    output logic                o_DONE,
    output logic                o_OVERFLOW,
    output logic [15:0]         o_CHECKSUM
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = SDRAM_AW + 18;
    localparam logic [7:0]    LP_IDX  = 8'(ROM_INDEX);
    localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LP_HIGH = CW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                r_pend_vld;
    logic [SDRAM_AW-1:0] r_pend_addr;
    logic [15:0]         r_pend_data;
    logic [1:0]          r_pend_be;

    logic [EW-1:0]       r_fifo [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                r_req;
    logic [SDRAM_AW-1:0] r_addr;
    logic [15:0]         r_data;
    logic [1:0]          r_be;
    logic                r_busy;
    logic                r_done;
    logic                r_wait;
    logic                r_ovf;

    logic                w_idx_match;
    logic                w_accept;
    logic                w_start;
    logic [SDRAM_AW-1:0] w_waddr;
    logic                w_lane;
    logic [15:0]         w_mrg_data;
    logic [1:0]          w_mrg_be;
    logic                w_push;
    logic [EW-1:0]       w_push_entry;
    logic                w_pend_vld_nxt;
    logic [SDRAM_AW-1:0] w_pend_addr_nxt;
    logic [15:0]         w_pend_data_nxt;
    logic [1:0]          w_pend_be_nxt;
    logic                w_full;
    logic                w_wr_en;
    logic                w_drop;
    logic                w_pop;
    logic [CW-1:0]       w_count_nxt;
    logic                w_unused;

    // Bits above the word address and the upper index byte are intentionally ignored.
    assign w_unused    = &{1'b0, ioctl_index[15:8], ioctl_addr[26:SDRAM_AW+1]};
    assign w_idx_match = (ioctl_index[7:0] == LP_IDX);
    assign w_accept    = (r_state == ST_LOAD) && ioctl_wr && w_idx_match;
    assign w_start     = (r_state == ST_IDLE) && (w_state_nxt == ST_LOAD);
    assign w_waddr     = ioctl_addr[SDRAM_AW:1];
    assign w_lane      = ioctl_addr[0];
    assign w_full      = (r_count == LP_FULL);
    assign w_wr_en     = w_push && !w_full;
    assign w_drop      = w_push && w_full;
    assign w_pop       = r_req && i_SDRAM_ACK;

    // Next-state decode of the load sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = (ioctl_download && w_idx_match) ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_state_nxt = ioctl_download ? ST_LOAD : ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ((r_count == {CW{1'b0}}) && !r_req) ? ST_DONE : ST_DRAIN;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte packing: merge into the pending word or retire it to the FIFO (one push per cycle).
    always_comb begin
        w_push          = 1'b0;
        w_push_entry    = {r_pend_addr, r_pend_data, r_pend_be};
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_addr_nxt = r_pend_addr;
        w_pend_data_nxt = r_pend_data;
        w_pend_be_nxt   = r_pend_be;
        w_mrg_data      = r_pend_data;
        w_mrg_be        = r_pend_be;
        if (w_lane) begin
            w_mrg_data[15:8] = ioctl_data;
            w_mrg_be[1]      = 1'b1;
        end else begin
            w_mrg_data[7:0]  = ioctl_data;
            w_mrg_be[0]      = 1'b1;
        end
        if (w_accept) begin
            if (r_pend_vld && (r_pend_addr == w_waddr)) begin
                if (w_mrg_be == 2'b11) begin
                    w_push          = 1'b1;
                    w_push_entry    = {r_pend_addr, w_mrg_data, 2'b11};
                    w_pend_vld_nxt  = 1'b0;
                    w_pend_data_nxt = 16'h0000;
                    w_pend_be_nxt   = 2'b00;
                end else begin
                    w_pend_data_nxt = w_mrg_data;
                    w_pend_be_nxt   = w_mrg_be;
                end
            end else begin
                w_push          = r_pend_vld;
                w_pend_vld_nxt  = 1'b1;
                w_pend_addr_nxt = w_waddr;
                w_pend_data_nxt = w_lane ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
                w_pend_be_nxt   = w_lane ? 2'b10 : 2'b01;
            end
        end else if ((r_state == ST_FLUSH) && r_pend_vld) begin
            w_push          = 1'b1;
            w_pend_vld_nxt  = 1'b0;
            w_pend_data_nxt = 16'h0000;
            w_pend_be_nxt   = 2'b00;
        end else begin
            w_push = 1'b0;
        end
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wait  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_wait  <= (w_count_nxt >= LP_HIGH) || (w_state_nxt == ST_FLUSH) ||
                       (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_DONE);
            if (w_start) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Pending half-assembled word.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= {SDRAM_AW{1'b0}};
            r_pend_data <= 16'h0000;
            r_pend_be   <= 2'b00;
        end else begin
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_pend_be   <= w_pend_be_nxt;
        end
    end

    // Write FIFO storage and pointers; a push into a full FIFO is discarded.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= {EW{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_fifo[r_wr_ptr] <= w_push_entry;
                r_wr_ptr         <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
        end
    end

    // SDRAM request: latch the FIFO head, hold it until ACK, then idle for one cycle.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            r_req  <= 1'b0;
            r_addr <= {SDRAM_AW{1'b0}};
            r_data <= 16'h0000;
            r_be   <= 2'b00;
        end else if (w_pop) begin
            r_req <= 1'b0;
        end else if (!r_req && (r_count != {CW{1'b0}})) begin
            r_req                  <= 1'b1;
            {r_addr, r_data, r_be} <= r_fifo[r_rd_ptr];
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0] r_csum;

    // Wrapping sum of every accepted byte, restarted when a new load begins.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            r_csum <= 16'h0000;
        end else if (w_start) begin
            r_csum <= 16'h0000;
        end else if (w_accept) begin
            r_csum <= r_csum + {8'h00, ioctl_data};
        end
    end

    assign o_CHECKSUM = r_csum;
`else
    assign o_CHECKSUM = 16'h0000;
`endif

    assign ioctl_wait   = r_wait;
    assign o_SDRAM_REQ  = r_req;
    assign o_SDRAM_ADDR = r_addr;
    assign o_SDRAM_DATA = r_data;
    assign o_SDRAM_BE   = r_be;
    assign o_BUSY       = r_busy;
    assign o_DONE       = r_done;
    assign o_OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Randomised and directed bench for ioctl_rom_loader against a transaction-level model of the
// packing rules, FIFO occupancy and request handshake.
module tb_ioctl_rom_loader;
    localparam int AW = 22;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    be;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dl = 1'b0;
    logic [15:0]   idx = 16'h0000;
    logic          wr = 1'b0;
    logic [26:0]   addr = 27'd0;
    logic [7:0]    data = 8'h00;
    logic          ack = 1'b0;
    logic          wait_o, req, busy, done, ovf;
    logic [AW-1:0] saddr;
    logic [15:0]   sdata, cs;
    logic [1:0]    sbe;

    ioctl_rom_loader #(.ROM_INDEX(0), .SDRAM_AW(AW), .FIFO_DEPTH(4)) dut (
        .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n), .ioctl_download(dl), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_data(data), .ioctl_wait(wait_o),
        .o_SDRAM_REQ(req), .o_SDRAM_ADDR(saddr), .o_SDRAM_DATA(sdata), .o_SDRAM_BE(sbe),
        .i_SDRAM_ACK(ack), .o_BUSY(busy), .o_DONE(done), .o_OVERFLOW(ovf), .o_CHECKSUM(cs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    word_t         mq[$];
    word_t         log_q[$];
    int            m_occ;
    bit            m_req, m_load, m_flush, m_drain, m_donest, m_ovf, m_pv, m_pushed;
    logic [AW-1:0] m_pa;
    logic [15:0]   m_pd, m_cs;
    logic [1:0]    m_pb;

    function automatic void model_reset();
        mq.delete();
        m_occ = 0; m_req = 0; m_load = 0; m_flush = 0; m_drain = 0; m_donest = 0;
        m_ovf = 0; m_pv = 0; m_pa = '0; m_pd = 16'h0000; m_pb = 2'b00; m_cs = 16'h0000;
    endfunction

    function automatic void emit(input word_t w, input bit full_now);
        if (full_now) m_ovf = 1'b1;
        else begin
            mq.push_back(w);
            m_pushed = 1'b1;
        end
    endfunction

    // Single compare process: outputs of this cycle vs model, then advance model on this cycle's inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit full, popped, n_req, acc, ln;
            int occ_cur;
            logic [AW-1:0] wa;
            logic [15:0] exp_cs;
`ifdef IOCTL_LOADER_CHECKSUM_EN
            exp_cs = m_cs;
`else
            exp_cs = 16'h0000;
`endif
            chk("busy", busy, m_load | m_flush | m_drain | m_donest);
            chk("done", done, m_donest);
            chk("wait", wait_o, (m_occ >= 3) | m_flush | m_drain | m_donest);
            chk("overflow", ovf, m_ovf);
            chk("req", req, m_req);
            chk("checksum", cs, exp_cs);
            if (req && m_req && mq.size() > 0) chk("req_word", {saddr, sdata, sbe}, mq[0]);
            if (done) done_cnt++;

            occ_cur  = m_occ;
            full     = (m_occ == 4);
            popped   = m_req && ack;
            n_req    = m_req ? !ack : (m_occ > 0);
            m_pushed = 1'b0;
            acc      = m_load && wr && (idx[7:0] == 8'h00);
            if (acc) begin
                m_cs = m_cs + {8'h00, data};
                wa = addr[AW:1];
                ln = addr[0];
                if (m_pv && m_pa == wa) begin
                    if (ln) m_pd[15:8] = data; else m_pd[7:0] = data;
                    m_pb[ln] = 1'b1;
                    if (m_pb == 2'b11) begin
                        emit({m_pa, m_pd, m_pb}, full);
                        m_pv = 1'b0;
                    end
                end else begin
                    if (m_pv) emit({m_pa, m_pd, m_pb}, full);
                    m_pv = 1'b1;
                    m_pa = wa;
                    m_pd = ln ? {data, 8'h00} : {8'h00, data};
                    m_pb = ln ? 2'b10 : 2'b01;
                end
            end else if (m_flush && m_pv) begin
                emit({m_pa, m_pd, m_pb}, full);
                m_pv = 1'b0;
            end
            if (popped) begin
                log_q.push_back({saddr, sdata, sbe});
                void'(mq.pop_front());
            end
            m_occ = m_occ + int'(m_pushed) - int'(popped);
            if (m_donest) m_donest = 1'b0;
            else if (m_drain) begin
                if (occ_cur == 0 && !m_req) begin m_drain = 1'b0; m_donest = 1'b1; end
            end else if (m_flush) begin m_flush = 1'b0; m_drain = 1'b1; end
            else if (m_load) begin
                if (!dl) begin m_load = 1'b0; m_flush = 1'b1; end
            end else if (dl && idx[7:0] == 8'h00) begin
                m_load = 1'b1; m_ovf = 1'b0; m_cs = 16'h0000;
            end
            m_req = n_req;
        end
    end

    // ---------------- SDRAM acknowledger ----------------
    bit ack_en = 1'b1;
    bit ack_rand = 1'b0;
    int age = 0;
    int dly = 1;
    always @(posedge clk) begin
        #1;
        if (!rst_n || !req) begin
            ack = 1'b0; age = 0;
        end else if (ack_en && age >= dly) begin
            ack = 1'b1; age = 0;
            dly = ack_rand ? int'($urandom_range(0, 3)) : 1;
        end else begin
            ack = 1'b0; age++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] ix);
        idx = ix; dl = 1'b1;
        tick();
    endtask

    task automatic send(input logic [26:0] a, input logic [7:0] d, input bit honour);
        int n = 0;
        if (honour) begin
            while (wait_o && n < 1000) begin tick(); n++; end
            if (n >= 1000) chk("wait_bound", n < 1000, 1);
        end
        addr = a; data = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic finish_dl();
        int n = 0;
        dl = 1'b0;
        while (!done && n < 2000) begin tick(); n++; end
        chk("done_seen", done, 1);
        tick();
    endtask

    task automatic chk_log(input string nm, input int k, input word_t exp);
        word_t got;
        got = (k < log_q.size()) ? log_q[k] : '1;
        chk(nm, got, exp);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int d0;
        logic [26:0] ra;
        #23 rst_n = 1'b1;
        tick();
        chk("rst_req", req, 0);   chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_wait", wait_o, 0); chk("rst_ovf", ovf, 0); chk("rst_cs", cs, 0);
        chk("rst_addr", {saddr, sdata, sbe}, 0);

        // 1: four bytes, fixed ACK, latency pin
        log_q.delete(); d0 = done_cnt;
        start(16'h0000);
        send(27'd0, 8'h11, 1);
        addr = 27'd1; data = 8'h22; wr = 1'b1;
        tick(); wr = 1'b0;
        chk("t1_lat_n1", req, 0);
        tick();
        chk("t1_lat_n2", req, 1);
        send(27'd2, 8'h33, 1);
        send(27'd3, 8'h44, 1);
`ifdef IOCTL_LOADER_CHECKSUM_EN
        chk("t1_cs", cs, 16'h00AA);
`endif
        finish_dl();
        chk("t1_nwords", log_q.size(), 2);
        chk_log("t1_w0", 0, {22'd0, 16'h2211, 2'b11});
        chk_log("t1_w1", 1, {22'd1, 16'h4433, 2'b11});
        chk("t1_dones", done_cnt - d0, 1);
        chk("t1_ovf", ovf, 0);

        // 2: odd byte count, flush partial; upper index byte ignored
        log_q.delete();
        start(16'h0100);
        send(27'd0, 8'hAA, 1); send(27'd1, 8'hBB, 1); send(27'd2, 8'hCC, 1);
        finish_dl();
        chk("t2_nwords", log_q.size(), 2);
        chk_log("t2_w0", 0, {22'd0, 16'hBBAA, 2'b11});
        chk_log("t2_w1", 1, {22'd1, 16'h00CC, 2'b01});

        // 3: address jump retires partial word
        log_q.delete();
        start(16'h0000);
        send(27'd0, 8'h11, 1); send(27'd5, 8'h55, 1);
        finish_dl();
        chk("t3_nwords", log_q.size(), 2);
        chk_log("t3_w0", 0, {22'd0, 16'h0011, 2'b01});
        chk_log("t3_w1", 1, {22'd2, 16'h5500, 2'b10});

        // 4a: ACK stalled, stream honours wait, then resumes
        log_q.delete(); ack_en = 1'b0;
        start(16'h0000);
        fork
            for (int i = 0; i < 16; i++) send(27'(i), 8'(8'h40 + i), 1);
            begin
                repeat (30) tick();
                chk("t4_wait_high", wait_o, 1);
                ack_en = 1'b1;
            end
        join
        finish_dl();
        chk("t4_nwords", log_q.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_log("t4_word", k, {22'(k), 8'(8'h41 + 2 * k), 8'(8'h40 + 2 * k), 2'b11});

        // 4b: forced write at full FIFO drops a word
        log_q.delete(); ack_en = 1'b0;
        start(16'h0000);
        for (int i = 0; i < 10; i++) send(27'(i), 8'(8'h60 + i), 0);
        chk("t4_ovf_set", ovf, 1);
        ack_en = 1'b1;
        finish_dl();
        chk("t4b_nwords", log_q.size(), 4);
        for (int k = 0; k < 4; k++)
            chk_log("t4b_word", k, {22'(k), 8'(8'h61 + 2 * k), 8'(8'h60 + 2 * k), 2'b11});
        chk("t4_ovf_sticky", ovf, 1);

        // 5: non-matching index ignored
        log_q.delete(); d0 = done_cnt;
        start(16'h0001);
        for (int i = 0; i < 4; i++) send(27'(i), 8'(i + 1), 1);
        dl = 1'b0;
        repeat (10) tick();
        chk("t5_nwords", log_q.size(), 0);
        chk("t5_dones", done_cnt - d0, 0);
        chk("t5_busy", busy, 0);

        // 6: asynchronous reset during DRAIN with REQ high
        ack_en = 1'b0;
        start(16'h0000);
        for (int i = 0; i < 4; i++) send(27'(i), 8'(8'h70 + i), 1);
        dl = 1'b0;
        repeat (4) tick();
        chk("t6_req_pre", req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_async", req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_wait", wait_o, 0);
        repeat (2) tick();
        rst_n = 1'b1; ack_en = 1'b1;
        tick();
        log_q.delete();
        start(16'h0000);
        send(27'd8, 8'h5A, 1); send(27'd9, 8'hA5, 1);
        finish_dl();
        chk("t6_nwords", log_q.size(), 1);
        chk_log("t6_w0", 0, {22'd4, 16'hA55A, 2'b11});

        // randomized downloads
        ack_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            logic [15:0] ix;
            bit match;
            match = ($urandom_range(0, 7) != 0);
            ix = match ? {8'($urandom), 8'h00} : {8'($urandom), 8'h07};
            start(ix);
            ra = 27'($urandom);
            for (int j = 0; j < int'($urandom_range(1, 40)); j++) begin
                case ($urandom_range(0, 9))
                    0:       ra = 27'($urandom);
                    1:       ra = ra;
                    default: ra = ra + 27'd1;
                endcase
                send(ra, 8'($urandom), 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
            if (match) finish_dl();
            else begin dl = 1'b0; repeat (5) tick(); end
        end
        repeat (5) tick();
        chk("final_queue_empty", mq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
